// File: rtl/riscv_ctrl_pkg.sv
// Shared decode constants for the RV64I ID-stage control unit: major opcodes,
// ALU operation and write-back select encodings, and the bundled control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_LUI   = 4'b1010,
        ALU_AUIPC = 4'b1011
    } alu_op_e;

    // 2'b11 is reserved and never produced by the decoder.
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        logic    alu_src;
        alu_op_e alu_op;
        wb_sel_e wb_sel;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/riscv_alu_op_decoder.sv
// ALU operation decode shared by OP (register) and OP-IMM (immediate) instructions.
// For immediates funct7[0] is shamt[5], so only funct7[6:1] qualifies shifts.
module riscv_alu_op_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_reg,
    output alu_op_e    alu_op,
    output logic       sub_illegal
);

    logic base_s;
    logic alt_s;

    assign base_s = is_reg ? (funct7 == 7'b0000000) : (funct7[6:1] == 6'b000000);
    assign alt_s  = is_reg ? (funct7 == 7'b0100000) : (funct7[6:1] == 6'b010000);

    // Select the ALU operation from funct3 and qualify it against funct7.
    always_comb begin
        alu_op      = ALU_ADD;
        sub_illegal = 1'b0;
        case (funct3)
            3'b000: begin
                if (is_reg && alt_s) begin
                    alu_op = ALU_SUB;
                end else if (!is_reg || base_s) begin
                    alu_op = ALU_ADD;
                end else begin
                    sub_illegal = 1'b1;
                end
            end
            3'b001: begin
                if (base_s) begin
                    alu_op = ALU_SLL;
                end else begin
                    sub_illegal = 1'b1;
                end
            end
            3'b101: begin
                if (base_s) begin
                    alu_op = ALU_SRL;
                end else if (alt_s) begin
                    alu_op = ALU_SRA;
                end else begin
                    sub_illegal = 1'b1;
                end
            end
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: sub_illegal = 1'b1;
        endcase
        // Non-shift register forms accept only funct7 = 0000000.
        if (is_reg && !base_s && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b101)) begin
            sub_illegal = 1'b1;
        end else begin
            sub_illegal = sub_illegal;
        end
    end

endmodule

// File: rtl/riscv_control_unit.sv
// RV64I ID-stage main decoder: combinational control generation plus a sticky
// flag and saturating counter of illegal instructions for debug/CSR visibility.
module riscv_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic             jump,
    output logic             alu_src,
    output logic [3:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             illegal_instr,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] illegal_count
);

    ctrl_t            ctrl_s;
    ctrl_t            out_s;
    logic             illegal_s;
    logic             is_reg_s;
    alu_op_e          dec_alu_op_s;
    logic             dec_illegal_s;
    logic             illegal_seen_r;
    logic [CNT_W-1:0] illegal_count_r;

    assign is_reg_s = (opcode == OPC_OP);

    riscv_alu_op_decoder u_alu_op_decoder (
        .funct3      (funct3),
        .funct7      (funct7),
        .is_reg      (is_reg_s),
        .alu_op      (dec_alu_op_s),
        .sub_illegal (dec_illegal_s)
    );

    // Opcode decode into a raw control word plus an illegal-encoding flag.
    always_comb begin
        ctrl_s    = CTRL_NOP;
        illegal_s = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALU_LUI;
            end
            OPC_AUIPC: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.alu_op    = ALU_AUIPC;
            end
            OPC_JAL: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.wb_sel    = WB_PC4;
            end
            OPC_JALR: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.jump      = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.wb_sel    = WB_PC4;
                illegal_s        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl_s.branch = 1'b1;
                illegal_s     = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                ctrl_s.wb_sel    = WB_MEM;
                illegal_s        = (funct3 == 3'b111);
            end
            OPC_STORE: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                illegal_s        = funct3[2];
            end
            OPC_OP_IMM, OPC_OP: begin
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = !is_reg_s;
                ctrl_s.alu_op    = dec_alu_op_s;
                illegal_s        = dec_illegal_s;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                ctrl_s = CTRL_NOP;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // An illegal encoding must leave no architectural side effect.
    always_comb begin
        if (illegal_s) begin
            out_s = CTRL_NOP;
        end else begin
            out_s = ctrl_s;
        end
    end

    assign reg_write     = out_s.reg_write;
    assign mem_read      = out_s.mem_read;
    assign mem_write     = out_s.mem_write;
    assign branch        = out_s.branch;
    assign jump          = out_s.jump;
    assign alu_src       = out_s.alu_src;
    assign alu_op        = out_s.alu_op;
    assign wb_sel        = out_s.wb_sel;
    assign illegal_instr = illegal_s;

    // Sticky illegal flag and saturating illegal counter; reset wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_seen_r  <= 1'b0;
            illegal_count_r <= {CNT_W{1'b0}};
        end else if (instr_valid && illegal_s) begin
            illegal_seen_r <= 1'b1;
            if (illegal_count_r != {CNT_W{1'b1}}) begin
                illegal_count_r <= illegal_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                illegal_count_r <= illegal_count_r;
            end
        end else begin
            illegal_seen_r  <= illegal_seen_r;
            illegal_count_r <= illegal_count_r;
        end
    end

    assign illegal_seen  = illegal_seen_r;
    assign illegal_count = illegal_count_r;

endmodule

// File: tb/tb_riscv_control_unit.sv
// Self-checking bench: directed and random decode against a rule-level model,
// plus sticky-flag / saturating-counter behaviour across reset and gating.
module tb_riscv_control_unit;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             instr_valid;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             reg_write, mem_read, mem_write, branch, jump, alu_src;
    logic [3:0]       alu_op;
    logic [1:0]       wb_sel;
    logic             illegal_instr, illegal_seen;
    logic [CNT_W-1:0] illegal_count;

    int checks = 0;
    int errors = 0;
    int seen_m;
    int count_m;

    riscv_control_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_src(alu_src),
        .alu_op(alu_op), .wb_sel(wb_sel), .illegal_instr(illegal_instr),
        .illegal_seen(illegal_seen), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode: {illegal, rw, mr, mw, br, jp, src, alu_op[3:0], wb[1:0]}
    function automatic logic [12:0] ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int base_op [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int rw = 0, mr = 0, mw = 0, br = 0, jp = 0, src = 0, aop = 0, wb = 0;
        bit legal = 1;
        case (op)
            7'b0110111: begin rw = 1; src = 1; aop = 10; end
            7'b0010111: begin rw = 1; src = 1; aop = 11; end
            7'b1101111: begin rw = 1; jp = 1; wb = 2; end
            7'b1100111: begin rw = 1; jp = 1; src = 1; wb = 2; legal = (f3 == 0); end
            7'b1100011: begin br = 1; legal = (f3 != 2) && (f3 != 3); end
            7'b0000011: begin rw = 1; mr = 1; src = 1; wb = 1; legal = (f3 != 7); end
            7'b0100011: begin mw = 1; src = 1; legal = (f3 < 4); end
            7'b0010011: begin
                rw = 1; src = 1; aop = base_op[f3];
                if (f3 == 1) legal = (f7[6:1] == 0);
                if (f3 == 5) begin
                    if (f7[6:1] == 6'b010000) aop = 7;
                    else legal = (f7[6:1] == 0);
                end
            end
            7'b0110011: begin
                rw = 1;
                if (f7 == 0) aop = base_op[f3];
                else if (f7 == 7'b0100000 && f3 == 0) aop = 1;
                else if (f7 == 7'b0100000 && f3 == 5) aop = 7;
                else legal = 0;
            end
            7'b0001111, 7'b1110011: ;
            default: legal = 0;
        endcase
        if (!legal) return 13'h1000;
        return {1'b0, rw[0], mr[0], mw[0], br[0], jp[0], src[0], aop[3:0], wb[1:0]};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {illegal_instr, reg_write, mem_read, mem_write, branch, jump, alu_src, alu_op, wb_sel};
    endfunction

    // One clock: drive at negedge, check decode, then check counters after the edge.
    task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic r);
        logic [12:0] exp;
        instr_valid = v; opcode = op; funct3 = f3; funct7 = f7; rst = r;
        #1;
        exp = ref_decode(op, f3, f7);
        check_eq($sformatf("ctrl op=%b f3=%b f7=%b", op, f3, f7), 32'(dut_vec()), 32'(exp));
        @(posedge clk);
        if (r) begin
            seen_m = 0; count_m = 0;
        end else if (v && exp[12]) begin
            seen_m = 1;
            if (count_m < CNT_MAX) count_m++;
        end
        @(negedge clk);
        check_eq("illegal_seen", 32'(illegal_seen), 32'(seen_m));
        check_eq("illegal_count", 32'(illegal_count), 32'(count_m));
    endtask

    logic [16:0] directed [] = '{
        {7'b0110111, 3'b000, 7'b0000000}, {7'b0010111, 3'b101, 7'b1010101},
        {7'b1101111, 3'b011, 7'b1111111}, {7'b1100111, 3'b000, 7'b0000000},
        {7'b1100011, 3'b000, 7'b0000000}, {7'b1100011, 3'b001, 7'b0000000},
        {7'b0000011, 3'b000, 7'b0000000}, {7'b0000011, 3'b010, 7'b0000000},
        {7'b0000011, 3'b011, 7'b0000000}, {7'b0100011, 3'b000, 7'b0000000},
        {7'b0100011, 3'b010, 7'b0000000}, {7'b0100011, 3'b011, 7'b0000000},
        {7'b0010011, 3'b000, 7'b1111111}, {7'b0010011, 3'b010, 7'b0000000},
        {7'b0010011, 3'b011, 7'b0000000}, {7'b0010011, 3'b100, 7'b0000000},
        {7'b0010011, 3'b001, 7'b0000001}, {7'b0010011, 3'b101, 7'b0000000},
        {7'b0010011, 3'b101, 7'b0100000}, {7'b0010011, 3'b101, 7'b0100001},
        {7'b0110011, 3'b000, 7'b0000000}, {7'b0110011, 3'b000, 7'b0100000},
        {7'b0110011, 3'b001, 7'b0000000}, {7'b0110011, 3'b010, 7'b0000000},
        {7'b0110011, 3'b100, 7'b0000000}, {7'b0110011, 3'b110, 7'b0000000},
        {7'b0110011, 3'b111, 7'b0000000}, {7'b0110011, 3'b101, 7'b0100000},
        {7'b0001111, 3'b000, 7'b0000000}, {7'b1110011, 3'b000, 7'b0000000}
    };

    logic [6:0] known_ops [11] = '{
        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
        7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011
    };

    logic [6:0] f7_pool [4] = '{7'b0000000, 7'b0100000, 7'b0100001, 7'b0000001};

    initial begin
        logic [6:0] op;
        logic [6:0] f7;
        logic [16:0] vec;
        rst = 1'b1; instr_valid = 1'b0; opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0;
        seen_m = 0; count_m = 0;
        @(negedge clk);

        // Reset for two cycles while an illegal opcode is presented.
        step(1'b1, 7'b1111111, 3'b000, 7'b0000000, 1'b1);
        step(1'b1, 7'b1111111, 3'b000, 7'b0000000, 1'b1);

        // Legal decode sweep; none of these may count.
        foreach (directed[i]) begin
            vec = directed[i];
            step(1'b1, vec[16:10], vec[9:7], vec[6:0], 1'b0);
        end

        // Three valid illegal encodings, then one gated by instr_valid=0.
        step(1'b1, 7'b1111111, 3'b000, 7'b0000000, 1'b0);
        step(1'b1, 7'b0110011, 3'b000, 7'b0000001, 1'b0);
        step(1'b1, 7'b1100011, 3'b010, 7'b0000000, 1'b0);
        step(1'b0, 7'b0100011, 3'b100, 7'b0000000, 1'b0);

        // Random decode with mostly-known opcodes and shift-relevant funct7 values.
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 3) != 0) ? known_ops[$urandom_range(0, 10)] : 7'($urandom);
            f7 = ($urandom_range(0, 1) != 0) ? f7_pool[$urandom_range(0, 3)] : 7'($urandom);
            step(1'($urandom), op, 3'($urandom), f7, 1'b0);
        end

        // Reset beats a simultaneous illegal event.
        step(1'b1, 7'b1111111, 3'b000, 7'b0000000, 1'b1);

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 7'b1111111, 3'($urandom), 7'($urandom), 1'b0);
        end
        check_eq("count_saturated", 32'(illegal_count), 32'(CNT_MAX));

        // Decode follows inputs with rst held and no clock edge in between.
        rst = 1'b1; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = known_ops[i * 2]; funct3 = 3'b000; funct7 = 7'b0000000;
            #1;
            check_eq("comb_in_reset", 32'(dut_vec()), 32'(ref_decode(opcode, funct3, funct7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
